// File: rtl/led_trail_pwm.sv
// led_trail_pwm: turns the chaser's one-hot pattern into a fading comet tail driven through a shared PWM comparator.
// Optional macro LED_GAMMA_EN: maps levels through a perceptual gamma LUT (requires LVL_W == 4).
module led_trail_pwm #(
    parameter int N_LED   = 8,
    parameter int LVL_W   = 4,
    parameter int DECAY   = 3,
    parameter int PWM_DIV = 1000
) (
    input  logic             clock_50,
    input  logic             rs,
    input  logic             tick,
    input  logic [N_LED-1:0] pattern_in,
    output logic [N_LED-1:0] led_out,
    output logic             frame
);
    localparam int MAX   = (1 << LVL_W) - 1;
    localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    localparam logic [LVL_W-1:0] MAX_LVL   = LVL_W'(MAX);
    localparam logic [LVL_W-1:0] LAST_SLOT = LVL_W'(MAX - 1);
    localparam logic [LVL_W-1:0] DECAY_L   = LVL_W'(DECAY);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PWM_DIV - 1);

    logic [LVL_W-1:0] r_level [N_LED];
    logic [LVL_W-1:0] w_eff   [N_LED];
    logic [DIV_W-1:0] r_div_cnt;
    logic [LVL_W-1:0] r_pwm_cnt;
    logic             w_step;

    // Decay floors at zero so a dim LED never wraps back to bright.
    function automatic logic [LVL_W-1:0] sat_decay(input logic [LVL_W-1:0] lvl);
        return (lvl > DECAY_L) ? lvl - DECAY_L : '0;
    endfunction

`ifdef LED_GAMMA_EN
    function automatic logic [LVL_W-1:0] gamma(input logic [LVL_W-1:0] lvl);
        logic [LVL_W-1:0] g;
        case (lvl)
            4'd0, 4'd1, 4'd2:  g = 4'd0;
            4'd3, 4'd4, 4'd5:  g = 4'd1;
            4'd6, 4'd7:        g = 4'd2;
            4'd8:              g = 4'd3;
            4'd9:              g = 4'd4;
            4'd10:             g = 4'd5;
            4'd11:             g = 4'd6;
            4'd12:             g = 4'd8;
            4'd13:             g = 4'd10;
            4'd14:             g = 4'd12;
            default:           g = 4'd15;
        endcase
        return g;
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < N_LED; i++) begin
`ifdef LED_GAMMA_EN
            w_eff[i] = gamma(r_level[i]);
`else
            w_eff[i] = r_level[i];
`endif
        end
    end

    assign w_step = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clock_50) begin
        if (rs) begin
            r_div_cnt <= '0;
            r_pwm_cnt <= '0;
            frame     <= 1'b0;
            led_out   <= '0;
            for (int i = 0; i < N_LED; i++) r_level[i] <= '0;
        end else begin
            r_div_cnt <= w_step ? '0 : r_div_cnt + 1'b1;
            frame     <= w_step && (r_pwm_cnt == LAST_SLOT);
            if (w_step) r_pwm_cnt <= (r_pwm_cnt == LAST_SLOT) ? '0 : r_pwm_cnt + 1'b1;
            if (tick) begin
                for (int i = 0; i < N_LED; i++)
                    r_level[i] <= pattern_in[i] ? MAX_LVL : sat_decay(r_level[i]);
            end
            // Slots run 0..MAX-1, so a MAX level never sees a dark slot.
            for (int i = 0; i < N_LED; i++) led_out[i] <= (w_eff[i] > r_pwm_cnt);
        end
    end
endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed bench for led_trail_pwm: three instances (fast PWM, PWM_DIV=4, DECAY=13) share the stimulus.
`timescale 1ns/1ps
module tb_led_trail_pwm;
    logic       clk = 1'b0;
    logic       rs, tick;
    logic [7:0] pat;
    logic [7:0] led_a, led_b, led_c;
    logic       fr_a, fr_b, fr_c;
    int         total = 0;
    int         bad = 0;
    int         lvl_a [8];
    int         lvl_c [8];

    always #5 clk = ~clk;

    led_trail_pwm #(.N_LED(8), .LVL_W(4), .DECAY(3), .PWM_DIV(1)) u_a (
        .clock_50(clk), .rs(rs), .tick(tick), .pattern_in(pat), .led_out(led_a), .frame(fr_a));
    led_trail_pwm #(.N_LED(8), .LVL_W(4), .DECAY(3), .PWM_DIV(4)) u_b (
        .clock_50(clk), .rs(rs), .tick(tick), .pattern_in(pat), .led_out(led_b), .frame(fr_b));
    led_trail_pwm #(.N_LED(8), .LVL_W(4), .DECAY(13), .PWM_DIV(1)) u_c (
        .clock_50(clk), .rs(rs), .tick(tick), .pattern_in(pat), .led_out(led_c), .frame(fr_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int eff(input int l);
`ifdef LED_GAMMA_EN
        int lut [16] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 8, 10, 12, 15};
        return lut[l];
`else
        return l;
`endif
    endfunction

    function automatic int decay_to(input int l, input int d);
        return (l <= d) ? 0 : l - d;
    endfunction

    task automatic model_tick(input logic [7:0] p);
        for (int i = 0; i < 8; i++) begin
            lvl_a[i] = p[i] ? 15 : decay_to(lvl_a[i], 3);
            lvl_c[i] = p[i] ? 15 : decay_to(lvl_c[i], 13);
        end
    endtask

    // Tick held for n cycles; afterwards pattern is scrambled to show it is ignored without tick.
    task automatic do_tick(input logic [7:0] p, input int n);
        tick = 1'b1;
        pat  = p;
        repeat (n) begin
            @(negedge clk);
            model_tick(p);
        end
        tick = 1'b0;
        pat  = ~p;
    endtask

    // 60 samples = 4 periods of A/C and 1 period of B, so on-count is 4*eff for every instance.
    task automatic measure(input string tag);
        int ca [8];
        int cb [8];
        int cc [8];
        int fa, fb, fc;
        fa = 0; fb = 0; fc = 0;
        for (int i = 0; i < 8; i++) begin
            ca[i] = 0; cb[i] = 0; cc[i] = 0;
        end
        @(negedge clk);
        repeat (60) begin
            for (int i = 0; i < 8; i++) begin
                ca[i] += int'(led_a[i]);
                cb[i] += int'(led_b[i]);
                cc[i] += int'(led_c[i]);
            end
            fa += int'(fr_a);
            fb += int'(fr_b);
            fc += int'(fr_c);
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_A_led%0d", tag, i), ca[i], 4 * eff(lvl_a[i]));
            check($sformatf("%s_B_led%0d", tag, i), cb[i], 4 * eff(lvl_a[i]));
            check($sformatf("%s_C_led%0d", tag, i), cc[i], 4 * eff(lvl_c[i]));
        end
        check({tag, "_A_frames"}, fa, 4);
        check({tag, "_B_frames"}, fb, 1);
        check({tag, "_C_frames"}, fc, 4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, na, nb;
        for (int i = 0; i < 8; i++) begin
            lvl_a[i] = 0;
            lvl_c[i] = 0;
        end
        rs = 1'b1; tick = 1'b1; pat = 8'hFF;
        repeat (2) begin
            @(negedge clk);
            check("rst_led_a", led_a, 0);
            check("rst_led_b", led_b, 0);
            check("rst_frame_a", fr_a, 0);
            check("rst_frame_b", fr_b, 0);
        end
        rs = 1'b0; tick = 1'b0; pat = 8'h00;

        do_tick(8'h80, 1);
        measure("t80");

        n = 0;
        while (fr_a !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("frame_seen_a", n < 40, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fr_a !== 1'b1 && n < 40);
        check("frame_period_a", n, 15);

        do_tick(8'h40, 1);
        measure("t40");
        do_tick(8'h20, 1);
        measure("t20");
        do_tick(8'h10, 1);
        measure("t10");
        do_tick(8'h00, 1);
        do_tick(8'h00, 1);
        do_tick(8'h00, 3);
        measure("zero");
        do_tick(8'hFF, 1);
        measure("ff");

        rs = 1'b1; tick = 1'b1; pat = 8'h01;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            lvl_a[i] = 0;
            lvl_c[i] = 0;
        end
        check("rst_tick_led_a", led_a, 0);
        check("rst_tick_led_b", led_b, 0);
        check("rst_tick_led_c", led_c, 0);
        check("rst_tick_frame_a", fr_a, 0);
        rs = 1'b0; tick = 1'b0; pat = 8'h00;

        na = 0; nb = 0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (fr_a === 1'b1 && na == 0) na = c;
            if (fr_b === 1'b1 && nb == 0) nb = c;
        end
        check("first_frame_a", na, 15);
        check("first_frame_b", nb, 60);
        measure("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
